// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between N_REQ byte producers.
// A granted producer owns the port for a burst of up to MAX_BURST bytes; writes stall on fifo_full.
module fifo_wr_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned BEAT_W    = $clog2(MAX_BURST + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          ack,
  output logic [N_REQ-1:0]          grant,
  output logic                      busy,
  input  logic                      fifo_full,
  output logic                      fifo_wr,
  output logic [DATA_W-1:0]         fifo_data
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [N_REQ-1:0]   grant_nxt;
  logic               busy_nxt;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [PTR_W-1:0]   owner, owner_nxt;
  logic [BEAT_W-1:0]  beat, beat_nxt;

  logic               found;
  logic [PTR_W-1:0]   sel;
  logic               owner_req;
  logic [DATA_W-1:0]  owner_data;
  logic [PTR_W-1:0]   owner_inc;
  logic               last_beat;

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] a, input int unsigned b);
    int unsigned s;
    s = 32'(a) + b;
    if (s >= N_REQ) s = s - N_REQ;
    return PTR_W'(s);
  endfunction

  // First requester at or after rr_ptr, wrapping modulo N_REQ
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && req[wrap_add(rr_ptr, i)]) begin
        found = 1'b1;
        sel   = wrap_add(rr_ptr, i);
      end
    end
  end

  // Owner's request and byte
  always_comb begin
    owner_req  = req[owner];
    owner_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (owner == PTR_W'(k)) owner_data = req_data[k*DATA_W +: DATA_W];
    end
  end

  assign owner_inc = wrap_add(owner, 1);
  assign last_beat = (beat == BEAT_W'(MAX_BURST - 1));

  // Next-state and write-port outputs
  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    busy_nxt   = busy;
    rr_ptr_nxt = rr_ptr;
    owner_nxt  = owner;
    beat_nxt   = beat;
    fifo_wr    = 1'b0;
    fifo_data  = '0;
    ack        = '0;

    case (state)
      IDLE: begin
        if (found) begin
          owner_nxt = sel;
          grant_nxt = N_REQ'(1) << sel;
          busy_nxt  = 1'b1;
          beat_nxt  = '0;
          state_nxt = BURST;
        end
      end
      BURST: begin
        fifo_data = owner_data;
        fifo_wr   = owner_req & ~fifo_full & ~reset;
        ack       = fifo_wr ? (N_REQ'(1) << owner) : '0;
        if (fifo_wr) begin
          if (last_beat) begin
            state_nxt  = IDLE;
            grant_nxt  = '0;
            busy_nxt   = 1'b0;
            rr_ptr_nxt = owner_inc;
          end else begin
            beat_nxt = beat + BEAT_W'(1);
          end
        end else if (!owner_req) begin
          // Owner withdrew: give up the port, keep beat as-is
          state_nxt  = IDLE;
          grant_nxt  = '0;
          busy_nxt   = 1'b0;
          rr_ptr_nxt = owner_inc;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      grant  <= '0;
      busy   <= 1'b0;
      rr_ptr <= '0;
      owner  <= '0;
      beat   <= '0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      busy   <= busy_nxt;
      rr_ptr <= rr_ptr_nxt;
      owner  <= owner_nxt;
      beat   <= beat_nxt;
    end
  end

  a_grant_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(grant));
  a_wr_ack_grant:  assert property (@(posedge clk) disable iff (reset) fifo_wr |-> (ack == grant));
  a_beat_bound:    assert property (@(posedge clk) disable iff (reset) beat <= BEAT_W'(MAX_BURST - 1));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, single burst, round robin, full stall,
// early release and mid-burst reset, checked cycle by cycle against hand-computed values.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [3:0]  grant;
  logic        busy;
  logic        fifo_full;
  logic        fifo_wr;
  logic [7:0]  fifo_data;

  int          n_checks;
  int          n_fail;

  // Producer model: requester k offers base[k]+cnt[k] while en[k] and cnt[k] < lim[k]
  logic [7:0]  base [4];
  int          cnt  [4];
  int          lim  [4];
  logic [3:0]  en;

  fifo_wr_arbiter #(
    .N_REQ(4), .DATA_W(8), .MAX_BURST(4)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .ack(ack), .grant(grant), .busy(busy),
    .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_data(fifo_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: drive producers, check outputs, advance acked producers at the edge
  task automatic tick(input string tag, input logic [3:0] eg, input logic eb,
                      input logic ew, input logic [7:0] ed);
    logic [3:0] ack_s;
    for (int k = 0; k < 4; k++) begin
      req[k] = en[k] && (cnt[k] < lim[k]);
      req_data[k*8 +: 8] = 8'(base[k] + cnt[k]);
    end
    #1;
    check({tag, ":grant"}, 32'(grant), 32'(eg));
    check({tag, ":busy"}, 32'(busy), 32'(eb));
    check({tag, ":fifo_wr"}, 32'(fifo_wr), 32'(ew));
    check({tag, ":ack"}, 32'(ack), 32'(ew ? eg : 4'b0000));
    if (ew || !eb) check({tag, ":data"}, 32'(fifo_data), 32'(ed));
    ack_s = ack;
    @(posedge clk);
    for (int k = 0; k < 4; k++) if (ack_s[k]) cnt[k]++;
    @(negedge clk);
  endtask

  task automatic zero_cnt();
    for (int k = 0; k < 4; k++) begin
      cnt[k] = 0;
      lim[k] = 100;
    end
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    tick("rstp0", 4'b0000, 1'b0, 1'b0, 8'h00);
    tick("rstp1", 4'b0000, 1'b0, 1'b0, 8'h00);
    reset = 1'b0;
  endtask

  initial begin
    int order [6];
    n_checks  = 0;
    n_fail    = 0;
    base[0]   = 8'h30;
    base[1]   = 8'h60;
    base[2]   = 8'hA0;
    base[3]   = 8'hD0;
    zero_cnt();
    order[0] = 0; order[1] = 1; order[2] = 3;
    order[3] = 0; order[4] = 1; order[5] = 3;
    reset     = 1'b1;
    fifo_full = 1'b0;
    en        = 4'b1111;
    req       = 4'b1111;
    req_data  = '0;
    @(negedge clk);

    // Reset held two cycles with every requester active
    tick("rst0", 4'b0000, 1'b0, 1'b0, 8'h00);
    tick("rst1", 4'b0000, 1'b0, 1'b0, 8'h00);
    reset = 1'b0;
    tick("rst_rel", 4'b0000, 1'b0, 1'b0, 8'h00);
    en = 4'b0000;
    tick("first_grant", 4'b0001, 1'b1, 1'b0, 8'h00);

    // Single requester 2, five bytes: burst of four, dead cycle, re-grant for the fifth
    zero_cnt();
    en = 4'b0100;
    lim[2] = 5;
    tick("sgl_idle", 4'b0000, 1'b0, 1'b0, 8'h00);
    tick("sgl_b0", 4'b0100, 1'b1, 1'b1, 8'hA0);
    tick("sgl_b1", 4'b0100, 1'b1, 1'b1, 8'hA1);
    tick("sgl_b2", 4'b0100, 1'b1, 1'b1, 8'hA2);
    tick("sgl_b3", 4'b0100, 1'b1, 1'b1, 8'hA3);
    tick("sgl_gap", 4'b0000, 1'b0, 1'b0, 8'h00);
    tick("sgl_b4", 4'b0100, 1'b1, 1'b1, 8'hA4);
    tick("sgl_rel", 4'b0100, 1'b1, 1'b0, 8'h00);
    tick("sgl_end", 4'b0000, 1'b0, 1'b0, 8'h00);

    // Round robin over 1011 from rr_ptr=0
    reset_pulse();
    zero_cnt();
    en = 4'b1011;
    tick("rr_idle", 4'b0000, 1'b0, 1'b0, 8'h00);
    for (int j = 0; j < 6; j++) begin
      for (int b = 0; b < 4; b++)
        tick("rr", 4'(1 << order[j]), 1'b1, 1'b1, 8'(base[order[j]] + 4 * (j / 3) + b));
      if (j == 5) en = 4'b0000;
      tick("rr_gap", 4'b0000, 1'b0, 1'b0, 8'h00);
    end

    // Full stall on requester 1 after its second byte
    zero_cnt();
    en = 4'b0010;
    tick("full_idle", 4'b0000, 1'b0, 1'b0, 8'h00);
    tick("full_b0", 4'b0010, 1'b1, 1'b1, 8'h60);
    tick("full_b1", 4'b0010, 1'b1, 1'b1, 8'h61);
    fifo_full = 1'b1;
    for (int s = 0; s < 5; s++) tick("full_stall", 4'b0010, 1'b1, 1'b0, 8'h00);
    fifo_full = 1'b0;
    en = 4'b0000;
    lim[1] = 4;
    en = 4'b0010;
    tick("full_b2", 4'b0010, 1'b1, 1'b1, 8'h62);
    tick("full_b3", 4'b0010, 1'b1, 1'b1, 8'h63);
    tick("full_end", 4'b0000, 1'b0, 1'b0, 8'h00);

    // Early release of requester 0 while requester 3 waits
    zero_cnt();
    en = 4'b0001;
    lim[0] = 2;
    tick("er_idle", 4'b0000, 1'b0, 1'b0, 8'h00);
    en = 4'b1001;
    tick("er_b0", 4'b0001, 1'b1, 1'b1, 8'h30);
    tick("er_b1", 4'b0001, 1'b1, 1'b1, 8'h31);
    tick("er_rel", 4'b0001, 1'b1, 1'b0, 8'h00);
    tick("er_gap", 4'b0000, 1'b0, 1'b0, 8'h00);
    for (int b = 0; b < 4; b++) tick("er_r3", 4'b1000, 1'b1, 1'b1, 8'(8'hD0 + b));
    en = 4'b0001;
    lim[0] = 4;
    tick("er_gap2", 4'b0000, 1'b0, 1'b0, 8'h00);
    tick("er_r0b2", 4'b0001, 1'b1, 1'b1, 8'h32);
    tick("er_r0b3", 4'b0001, 1'b1, 1'b1, 8'h33);
    tick("er_rel2", 4'b0001, 1'b1, 1'b0, 8'h00);
    en = 4'b0011;
    lim[0] = 100;
    tick("er_idle3", 4'b0000, 1'b0, 1'b0, 8'h00);
    tick("er_rrptr", 4'b0010, 1'b1, 1'b1, 8'h60);
    en = 4'b0000;
    tick("er_rel3", 4'b0010, 1'b1, 1'b0, 8'h00);
    tick("er_end", 4'b0000, 1'b0, 1'b0, 8'h00);

    // Reset on the third beat of a burst by requester 2
    zero_cnt();
    en = 4'b0100;
    tick("mr_idle", 4'b0000, 1'b0, 1'b0, 8'h00);
    tick("mr_b0", 4'b0100, 1'b1, 1'b1, 8'hA0);
    tick("mr_b1", 4'b0100, 1'b1, 1'b1, 8'hA1);
    reset = 1'b1;
    tick("mr_abort", 4'b0100, 1'b1, 1'b0, 8'h00);
    reset = 1'b0;
    zero_cnt();
    en = 4'b0110;
    tick("mr_after", 4'b0000, 1'b0, 1'b0, 8'h00);
    tick("mr_grant", 4'b0010, 1'b1, 1'b1, 8'h60);
    en = 4'b0000;
    tick("mr_rel", 4'b0010, 1'b1, 1'b0, 8'h00);
    tick("mr_end", 4'b0000, 1'b0, 1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
